mic_ram_writer: RTL and testbench

//  Write-side master for the exported on-chip RAM slave port (ram_block_s2) of nios_system.

---
 rtl/mic_ram_writer_if.sv | 23 ++
 rtl/mic_ram_writer.sv | 146 ++++++++++++++
 tb/tb_mic_ram_writer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mic_ram_writer_if.sv
// Write-side bus toward the on-chip RAM slave port (ram_block_s2).
// The master drives the write strobes; readdata returns from the RAM slave.
interface mic_ram_writer_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              clken;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;

  modport master (
    output address, chipselect, clken, write, writedata, byteenable,
    input  readdata
  );

  modport slave (
    input  address, chipselect, clken, write, writedata, byteenable,
    output readdata
  );
endinterface

// File: rtl/mic_ram_writer.sv
// Packs 16-bit mic samples two per word into a ping-pong RAM ring buffer, writes a
// header word {seq, drop_count} when a half fills, and hands that half to the Nios.
module mic_ram_writer #(
  parameter int ADDR_W   = 10,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                enable,
  input  logic                smp_valid,
  input  logic [SAMPLE_W-1:0] smp_data,
  mic_ram_writer_if.master    ram,
  input  logic [1:0]          buf_release,
  output logic [1:0]          buf_full,
  output logic                half_done,
  output logic                half_idx,
  output logic                overrun,
  output logic [15:0]         drop_count
);

  localparam int OFF_W = ADDR_W - 1;
  localparam logic [OFF_W-1:0] OFF_FIRST = OFF_W'(1);
  localparam logic [OFF_W-1:0] OFF_LAST  = '1;

  typedef enum logic [1:0] {IDLE, FILL, HDR, OVR} state_t;

  state_t              state, next_state;
  logic                cur_half;
  logic [OFF_W-1:0]    offset;
  logic                pack_phase;
  logic [SAMPLE_W-1:0] low_q;
  logic [15:0]         seq;
  logic                data_wr, hdr_wr;
  logic                other_half;
  logic [OFF_W-1:0]    wr_off;
  logic                unused_readdata;

  assign unused_readdata = ^ram.readdata;
  assign other_half      = ~cur_half;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Bus outputs are combinational from state so an async reset silences them at once
  always_comb begin
    next_state     = state;
    data_wr        = 1'b0;
    hdr_wr         = 1'b0;
    half_done      = 1'b0;
    half_idx       = 1'b0;
    overrun        = 1'b0;
    wr_off         = offset;
    ram.address    = '0;
    ram.chipselect = 1'b0;
    ram.clken      = 1'b0;
    ram.write      = 1'b0;
    ram.writedata  = '0;
    ram.byteenable = '0;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE: next_state = FILL;
        FILL: begin
          if (smp_valid && pack_phase) begin
            data_wr = 1'b1;
            if (offset == OFF_LAST) next_state = HDR;
          end
        end
        HDR: begin
          hdr_wr    = 1'b1;
          half_done = 1'b1;
          half_idx  = cur_half;
          wr_off    = '0;
          next_state = (buf_full[other_half] && !buf_release[other_half]) ? OVR : FILL;
        end
        OVR: begin
          overrun = 1'b1;
          if (buf_release[cur_half]) next_state = FILL;
        end
        default: next_state = IDLE;
      endcase
    end
    if (data_wr || hdr_wr) begin
      ram.address    = {cur_half, wr_off};
      ram.chipselect = 1'b1;
      ram.clken      = 1'b1;
      ram.write      = 1'b1;
      ram.byteenable = 4'hF;
      ram.writedata  = hdr_wr ? {seq, drop_count} : {smp_data, low_q};
    end
  end

  // Datapath: packing, offsets, header sequencing, ownership flags, drop accounting
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cur_half   <= 1'b0;
      offset     <= OFF_FIRST;
      pack_phase <= 1'b0;
      low_q      <= '0;
      seq        <= '0;
      drop_count <= '0;
      buf_full   <= '0;
    end else begin
      buf_full <= (buf_full & ~buf_release) | (hdr_wr ? (2'b01 << cur_half) : 2'b00);
      if (!enable || state == IDLE) begin
        pack_phase <= 1'b0;
        offset     <= OFF_FIRST;
      end else begin
        unique case (state)
          FILL: begin
            if (smp_valid) begin
              if (!pack_phase) begin
                low_q      <= smp_data;
                pack_phase <= 1'b1;
              end else begin
                pack_phase <= 1'b0;
                offset     <= offset + OFF_W'(1);
              end
            end
          end
          HDR: begin
            seq      <= seq + 16'd1;
            cur_half <= ~cur_half;
            offset   <= OFF_FIRST;
            if (smp_valid) begin
              low_q      <= smp_data;
              pack_phase <= 1'b1;
            end
          end
          OVR: begin
            if (smp_valid && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            if (buf_release[cur_half]) pack_phase <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mic_ram_writer.sv
// Directed bench for mic_ram_writer: fills both halves, overrun/drop handling,
// enable abort, drop saturation and asynchronous reset during a write.
module tb_mic_ram_writer;

  logic        clk_clk       = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        enable        = 1'b0;
  logic        smp_valid     = 1'b0;
  logic [15:0] smp_data      = '0;
  logic [1:0]  buf_release   = '0;
  logic [1:0]  buf_full;
  logic        half_done;
  logic        half_idx;
  logic        overrun;
  logic [15:0] drop_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int wr_count     = 0;
  int base;
  logic [31:0] mem [0:1023];

  mic_ram_writer_if #(.ADDR_W(10)) ram_if ();
  assign ram_if.readdata = 32'h0;

  mic_ram_writer #(.ADDR_W(10), .SAMPLE_W(16)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .enable        (enable),
    .smp_valid     (smp_valid),
    .smp_data      (smp_data),
    .ram           (ram_if),
    .buf_release   (buf_release),
    .buf_full      (buf_full),
    .half_done     (half_done),
    .half_idx      (half_idx),
    .overrun       (overrun),
    .drop_count    (drop_count)
  );

  always #5 clk_clk = ~clk_clk;

  // Behavioural RAM: captures every committed write
  always @(posedge clk_clk) begin
    if (ram_if.chipselect && ram_if.write) begin
      mem[ram_if.address] <= ram_if.writedata;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [15:0] d, input logic [1:0] rel);
    @(negedge clk_clk);
    smp_valid   = v;
    smp_data    = d;
    buf_release = rel;
    #1;
  endtask

  task automatic feed(input int n, input int start);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, 16'(start + i), 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk_clk);
    #1;
    check_output("rst_cs",   32'(ram_if.chipselect), 32'd0);
    check_output("rst_wr",   32'(ram_if.write),      32'd0);
    check_output("rst_be",   32'(ram_if.byteenable), 32'd0);
    check_output("rst_addr", 32'(ram_if.address),    32'd0);
    check_output("rst_full", 32'(buf_full),          32'd0);
    check_output("rst_drop", 32'(drop_count),        32'd0);
    check_output("rst_done", 32'(half_done),         32'd0);
    check_output("rst_ovr",  32'(overrun),           32'd0);
    reset_reset_n = 1'b1;
    enable        = 1'b1;

    // Half 0: samples 0..1021
    base = wr_count;
    apply_stimulus(1'b1, 16'd0, 2'b00);
    check_output("t1_lo_nowrite", 32'(ram_if.write), 32'd0);
    apply_stimulus(1'b1, 16'd1, 2'b00);
    check_output("t1_w1_write", 32'(ram_if.write),      32'd1);
    check_output("t1_w1_addr",  32'(ram_if.address),    32'd1);
    check_output("t1_w1_data",  ram_if.writedata,       32'h0001_0000);
    check_output("t1_w1_be",    32'(ram_if.byteenable), 32'hF);
    feed(1020, 2);
    apply_stimulus(1'b0, 16'd0, 2'b00);
    check_output("t1_nwrites",  32'(wr_count - base),  32'd511);
    check_output("t1_word511",  mem[511],              32'h03FD_03FC);
    check_output("t1_hdr_wr",   32'(ram_if.write),     32'd1);
    check_output("t1_hdr_addr", 32'(ram_if.address),   32'd0);
    check_output("t1_hdr_data", ram_if.writedata,      32'h0000_0000);
    check_output("t1_hdr_done", 32'(half_done),        32'd1);
    check_output("t1_hdr_idx",  32'(half_idx),         32'd0);
    apply_stimulus(1'b0, 16'd0, 2'b00);
    check_output("t1_full",       32'(buf_full),  32'b01);
    check_output("t1_done_pulse", 32'(half_done), 32'd0);

    // Half 1: samples 1022..2043, then overrun because half 0 is still owned
    feed(1022, 1022);
    apply_stimulus(1'b0, 16'd0, 2'b00);
    check_output("t2_word513",  mem[513],            32'h03FF_03FE);
    check_output("t2_hdr_addr", 32'(ram_if.address), 32'd512);
    check_output("t2_hdr_data", ram_if.writedata,    32'h0001_0000);
    check_output("t2_hdr_idx",  32'(half_idx),       32'd1);
    apply_stimulus(1'b0, 16'd0, 2'b00);
    check_output("t2_full", 32'(buf_full), 32'b11);
    check_output("t2_ovr",  32'(overrun),  32'd1);

    // Drop 5 samples, then release half 0
    base = wr_count;
    feed(5, 16'h5000);
    apply_stimulus(1'b0, 16'd0, 2'b00);
    check_output("t3_drop",     32'(drop_count),       32'd5);
    check_output("t3_nowrites", 32'(wr_count - base),  32'd0);
    apply_stimulus(1'b0, 16'd0, 2'b01);
    apply_stimulus(1'b0, 16'd0, 2'b00);
    check_output("t3_ovr_fall", 32'(overrun),  32'd0);
    check_output("t3_full",     32'(buf_full), 32'b10);
    apply_stimulus(1'b1, 16'hAAAA, 2'b00);
    apply_stimulus(1'b1, 16'hBBBB, 2'b00);
    check_output("t3_addr", 32'(ram_if.address), 32'd1);
    check_output("t3_data", ram_if.writedata,    32'hBBBB_AAAA);

    // Enable abort with a stale low sample pending
    apply_stimulus(1'b1, 16'hC001, 2'b00);
    apply_stimulus(1'b1, 16'hC002, 2'b00);
    check_output("t4_addr2", 32'(ram_if.address), 32'd2);
    apply_stimulus(1'b1, 16'hC003, 2'b00);
    apply_stimulus(1'b0, 16'd0, 2'b00);
    enable = 1'b0;
    apply_stimulus(1'b0, 16'd0, 2'b00);
    enable = 1'b1;
    apply_stimulus(1'b0, 16'd0, 2'b00);
    apply_stimulus(1'b1, 16'hD001, 2'b00);
    check_output("t4_stale", 32'(ram_if.write), 32'd0);
    apply_stimulus(1'b1, 16'hD002, 2'b00);
    check_output("t4_addr", 32'(ram_if.address), 32'd1);
    check_output("t4_data", ram_if.writedata,    32'hD002_D001);
    check_output("t4_full", 32'(buf_full),       32'b10);

    // Refill half 0 into overrun, then drop saturation
    feed(1020, 16'h1000);
    apply_stimulus(1'b0, 16'd0, 2'b00);
    check_output("t5_hdr_data", ram_if.writedata, 32'h0002_0005);
    check_output("t5_hdr_idx",  32'(half_idx),    32'd0);
    apply_stimulus(1'b0, 16'd0, 2'b00);
    check_output("t5_ovr",  32'(overrun),  32'd1);
    check_output("t5_full", 32'(buf_full), 32'b11);
    @(negedge clk_clk);
    force dut.drop_count = 16'hFFFE;
    #1;
    release dut.drop_count;
    base = wr_count;
    feed(1, 16'h7000);
    apply_stimulus(1'b0, 16'd0, 2'b00);
    check_output("t5_first_drop", 32'(drop_count), 32'hFFFF);
    feed(3, 16'h7001);
    apply_stimulus(1'b0, 16'd0, 2'b00);
    check_output("t5_sat",      32'(drop_count),      32'hFFFF);
    check_output("t5_nowrites", 32'(wr_count - base), 32'd0);

    // Asynchronous reset during a data write
    apply_stimulus(1'b0, 16'd0, 2'b10);
    apply_stimulus(1'b0, 16'd0, 2'b00);
    check_output("t6_ovr_fall", 32'(overrun), 32'd0);
    apply_stimulus(1'b1, 16'hE001, 2'b00);
    apply_stimulus(1'b1, 16'hE002, 2'b00);
    check_output("t6_pre_wr",   32'(ram_if.write),   32'd1);
    check_output("t6_pre_addr", 32'(ram_if.address), 32'd513);
    reset_reset_n = 1'b0;
    #1;
    check_output("t6_cs_async", 32'(ram_if.chipselect), 32'd0);
    check_output("t6_wr_async", 32'(ram_if.write),      32'd0);
    check_output("t6_full",     32'(buf_full),          32'd0);
    check_output("t6_drop",     32'(drop_count),        32'd0);
    apply_stimulus(1'b0, 16'd0, 2'b00);
    reset_reset_n = 1'b1;
    apply_stimulus(1'b1, 16'hF001, 2'b00);
    check_output("t6_lo_nowrite", 32'(ram_if.write), 32'd0);
    apply_stimulus(1'b1, 16'hF002, 2'b00);
    check_output("t6_addr", 32'(ram_if.address), 32'd1);
    check_output("t6_data", ram_if.writedata,    32'hF002_F001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
